// File: rtl/io_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_bank_pkg
// Brief    : Shared access-width, exception and FSM encodings for io_bank.
// Revision : 1.0 - initial release
// ============================================================================
package io_bank_pkg;

   localparam int EXCEPTION_LEN = 4;

   localparam logic [1:0] MEM_WIDTH_NONE = 2'd0;
   localparam logic [1:0] MEM_WIDTH_BYTE = 2'd1;
   localparam logic [1:0] MEM_WIDTH_HALF = 2'd2;
   localparam logic [1:0] MEM_WIDTH_WORD = 2'd3;

   localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK                = 4'd0;
   localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ  = 4'd5;
   localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_WRITE = 4'd7;

   typedef enum logic [1:0] {
      IO_STATE_IDLE = 2'd0,
      IO_STATE_WAIT = 2'd1,
      IO_STATE_DONE = 2'd2
   } io_state_t;

   // Byte lanes touched by an access of the given width at the given lane.
   function automatic logic [3:0] lane_mask(input logic [1:0] width, input logic [1:0] lane);
      case (width)
         MEM_WIDTH_BYTE: lane_mask = 4'b0001 << lane;
         MEM_WIDTH_HALF: lane_mask = 4'b0011 << lane;
         MEM_WIDTH_WORD: lane_mask = 4'b1111;
         default:        lane_mask = 4'b0000;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/io_sync.sv
`default_nettype none
// ============================================================================
// Module   : io_sync
// Brief    : Plain flop-chain synchroniser with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module io_sync #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_stage [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
      end else begin
         r_stage[0] <= i_data;
         for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_data = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/io_bank.sv
`default_nettype none
// ============================================================================
// Module   : io_bank
// Brief    : Memory-mapped bank of RW output and RO synchronised input channels.
// Revision : 1.0 - initial release
// ============================================================================
module io_bank
   import io_bank_pkg::*;
#(
   parameter int          NUM_CH      = 4,
   parameter int          LATENCY     = 1,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] RESET_VALUE = 32'h0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              addr_In,
   input  logic [31:0]              data_In,
   input  logic [1:0]               dataWidth_In,
   input  logic                     isRead_In,
   input  logic                     inputValid_In,
   output logic [31:0]              data_Out,
   output logic                     operationOK_Out,
   output logic [EXCEPTION_LEN-1:0] exception_Out,
   output logic [32*NUM_CH-1:0]     io_Out,
   input  logic [32*NUM_CH-1:0]     io_In,
   output logic [NUM_CH-1:0]        ioWriteStrobe_Out
);

   localparam int c_CH_BITS = $clog2(2*NUM_CH);
   localparam int c_AW      = c_CH_BITS + 2;
   localparam int c_CNT_W   = $clog2(LATENCY) + 1;

   io_state_t            r_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_AW-1:0]      r_addr;
   logic [31:0]          r_data;
   logic [1:0]           r_width;
   logic                 r_read;
   logic                 r_ok;
   logic [NUM_CH-1:0]    r_strobe;
   logic [31:0]          r_rdata;
   logic [32*NUM_CH-1:0] r_io;

   logic [32*NUM_CH-1:0] w_sync;
   logic                 w_bad;
   logic                 w_accept;
   logic                 w_enter_done;
   logic [c_AW-1:0]      w_e_addr;
   logic [31:0]          w_e_data;
   logic [1:0]           w_e_width;
   logic                 w_e_read;
   logic [1:0]           w_lane;
   logic [31:0]          w_ch_idx;
   logic [3:0]           w_mask;
   logic [31:0]          w_wdata_sh;
   logic [31:0]          w_rd_word;
   logic [31:0]          w_rd_shift;
   logic [31:0]          w_rd_data;

   io_sync #(.WIDTH(32*NUM_CH), .STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .i_data (io_In),
      .o_data (w_sync)
   );

   always_comb begin
      w_bad = 1'b0;
      if (addr_In >= 32'(8*NUM_CH)) w_bad = 1'b1;
      case (dataWidth_In)
         MEM_WIDTH_NONE: w_bad = 1'b1;
         MEM_WIDTH_HALF: if (addr_In[0]) w_bad = 1'b1;
         MEM_WIDTH_WORD: if (addr_In[1:0] != 2'b00) w_bad = 1'b1;
         default: ;
      endcase
      if (!isRead_In && (addr_In >= 32'(4*NUM_CH))) w_bad = 1'b1;
      exception_Out = EXCEP_OK;
      if (inputValid_In && w_bad)
         exception_Out = isRead_In ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
   end

   assign w_accept     = (r_state == IO_STATE_IDLE) && inputValid_In && !w_bad;
   assign w_enter_done = (w_accept && (LATENCY == 1)) ||
                         ((r_state == IO_STATE_WAIT) && (r_cnt == c_CNT_W'(1)));

   // With LATENCY=1 the commit happens on the accept edge, so use live inputs.
   assign w_e_addr   = (r_state == IO_STATE_IDLE) ? addr_In[c_AW-1:0] : r_addr;
   assign w_e_data   = (r_state == IO_STATE_IDLE) ? data_In           : r_data;
   assign w_e_width  = (r_state == IO_STATE_IDLE) ? dataWidth_In      : r_width;
   assign w_e_read   = (r_state == IO_STATE_IDLE) ? isRead_In         : r_read;

   assign w_lane     = w_e_addr[1:0];
   assign w_ch_idx   = 32'(w_e_addr[c_AW-1:2]);
   assign w_mask     = lane_mask(w_e_width, w_lane);
   assign w_wdata_sh = w_e_data << {w_lane, 3'b000};

   always_comb begin
      w_rd_word = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_ch_idx == 32'(i))          w_rd_word = r_io[32*i +: 32];
         if (w_ch_idx == 32'(NUM_CH + i)) w_rd_word = w_sync[32*i +: 32];
      end
      w_rd_shift = w_rd_word >> {w_lane, 3'b000};
      case (w_e_width)
         MEM_WIDTH_BYTE: w_rd_data = {24'h0, w_rd_shift[7:0]};
         MEM_WIDTH_HALF: w_rd_data = {16'h0, w_rd_shift[15:0]};
         default:        w_rd_data = w_rd_shift;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IO_STATE_IDLE;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_data   <= '0;
         r_width  <= MEM_WIDTH_NONE;
         r_read   <= 1'b0;
         r_ok     <= 1'b0;
         r_strobe <= '0;
         r_rdata  <= '0;
         r_io     <= {NUM_CH{RESET_VALUE}};
      end else begin
         r_ok     <= 1'b0;
         r_strobe <= '0;
         case (r_state)
            IO_STATE_IDLE: begin
               if (w_accept) begin
                  r_addr  <= addr_In[c_AW-1:0];
                  r_data  <= data_In;
                  r_width <= dataWidth_In;
                  r_read  <= isRead_In;
                  r_cnt   <= c_CNT_W'(LATENCY - 1);
                  r_state <= (LATENCY == 1) ? IO_STATE_DONE : IO_STATE_WAIT;
               end
            end
            IO_STATE_WAIT: begin
               r_cnt <= r_cnt - c_CNT_W'(1);
               if (r_cnt == c_CNT_W'(1)) r_state <= IO_STATE_DONE;
            end
            IO_STATE_DONE: r_state <= IO_STATE_IDLE;
            default:       r_state <= IO_STATE_IDLE;
         endcase

         if (w_enter_done) begin
            r_ok <= 1'b1;
            if (w_e_read) begin
               r_rdata <= w_rd_data;
            end else begin
               r_rdata <= '0;
               for (int i = 0; i < NUM_CH; i++) begin
                  if (w_ch_idx == 32'(i)) begin
                     r_strobe[i] <= 1'b1;
                     for (int b = 0; b < 4; b++)
                        if (w_mask[b]) r_io[32*i + 8*b +: 8] <= w_wdata_sh[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   assign data_Out          = r_rdata;
   assign operationOK_Out   = r_ok;
   assign ioWriteStrobe_Out = r_strobe;
   assign io_Out            = r_io;

endmodule
`default_nettype wire

// File: doc/io_bank.md
Name: io_bank

Overview:
- Parametrised memory-mapped IO bank for the rv32i data-memory path. Generalises the single 4-byte IO slot.
- Provides NUM_CH writable output channels (read-back) and NUM_CH read-only input channels, 32 bits each, with byte/half/word access.
- Access latency is configurable, with a held-valid/OK handshake; write strobes are per channel; input pins are synchronised.
- Sits behind the memory arbiter alongside RAM; same request/response port set as other memory slaves.

Parameters:
- NUM_CH, 4, number of output channels and of input channels (power of two, 1..16)
- LATENCY, 1, cycles from request acceptance to operationOK_Out (>=1)
- SYNC_STAGES, 2, flip-flop stages on io_In (>=1)
- RESET_VALUE, 32'h0, reset value of every output channel

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- addr_In  in  32  byte offset within bank
- data_In  in  32  write data, right-justified
- dataWidth_In  in  2  MEM_WIDTH_NONE/BYTE/HALF/WORD
- isRead_In  in  1  1=read, 0=write
- inputValid_In  in  1  request valid, held until operationOK_Out
- data_Out  out  32  read data, zero-extended, right-justified
- operationOK_Out  out  1  one-cycle completion pulse
- exception_Out  out  EXCEPTION_LEN  combinational request check
- io_Out  out  32*NUM_CH  output channel registers, channel i at [32i+:32]
- io_In  in  32*NUM_CH  asynchronous input pins
- ioWriteStrobe_Out  out  NUM_CH  pulse when channel i is written

Behaviour:
- Map: offsets 0..4*NUM_CH-1 are output channels (RW). Offsets 4*NUM_CH..8*NUM_CH-1 are input channels (RO, synchronised value). Channel index is addr[2+:log2(2*NUM_CH)]; byte lane is addr[1:0].
- exception_Out is combinational and reports EXCEP_OK unless inputValid_In is set and any of these holds: addr >= 8*NUM_CH; width NONE; HALF with addr[0]=1; WORD with addr[1:0]!=0; write to an input channel. On error: EXCEP_INVALID_MEM_READ if isRead_In, else EXCEP_INVALID_MEM_WRITE.
- A faulting request is never accepted: no state change, no OK, no strobe.
- FSM IDLE/WAIT/DONE:
  - IDLE: inputValid_In with EXCEP_OK captures addr/data/width/dir. Loads counter=LATENCY-1. Goes to DONE if LATENCY=1, else WAIT.
  - WAIT: decrements the counter; goes to DONE when it reaches 0.
  - DONE: operationOK_Out=1 for exactly this cycle; returns to IDLE. Inputs are ignored in WAIT and DONE.
- Timing: request sampled at edge k gives OK high in the cycle after edge k+LATENCY-1. A requester dropping valid in the OK cycle gives back-to-back throughput of one op per LATENCY+1 cycles.
- Write commit: at the edge entering DONE, only the addressed byte lanes of the channel update (byte: 1 lane; half: 2 lanes; word: all). The channel's ioWriteStrobe_Out is high during DONE.
- Read: data_Out is loaded at the edge entering DONE from the selected lanes, shifted down and zero-extended. Output-channel reads return io_Out; input-channel reads return the synchronised io_In. Writes load data_Out=0. data_Out holds until the next completion.
- Input sampling: a read returns the synchroniser output as of the DONE-entry edge.
- Reset, including mid-operation: FSM to IDLE, counter 0, data_Out=0, operationOK_Out=0, ioWriteStrobe_Out=0, io_Out=RESET_VALUE for all channels, synchroniser flops cleared. An in-flight write is discarded.

Decomposition:
- Add to shared src/constants.v: IO_STATE_IDLE/WAIT/DONE (2-bit encodings).
- Reuse the existing MEM_WIDTH_* and EXCEP_* constants.
- Sub-module io_sync (parameter WIDTH, STAGES): plain flop chain with synchronous reset, instantiated once for the full io_In bus.

Test Plan:
1. NUM_CH=4, LATENCY=1: write word 32'hDEADBEEF to addr 8 → OK and ioWriteStrobe_Out=4'b0100 one cycle after acceptance; io_Out[95:64]=DEADBEEF; read addr 8 → data_Out=DEADBEEF.
2. Byte write 8'h5A to addr 5, then half 16'h1234 to addr 6 over channel 1 = 0 → channel 1 = 32'h12345A00. Read byte addr 6 → 32'h34.
3. LATENCY=3: request at edge k → OK high only in the cycle after edge k+2; valid held through WAIT; no second op starts.
4. Exceptions: half at addr 3, word at addr 2, any access at addr 32, write to addr 16 → exception_Out is READ/WRITE code accordingly; no OK, no strobe, io_Out unchanged.
5. io_In channel 0 = 32'hCAFEF00D, SYNC_STAGES=2 → word read of addr 16 issued the cycle after the change returns the old value; after 2 cycles it returns CAFEF00D.
6. rst asserted during WAIT of a write (LATENCY=4) → no OK, no strobe, io_Out=RESET_VALUE, FSM back in IDLE; the next request completes normally.
